fetch_sequencer: RTL and testbench

//   Sequences instruction fetch between the program counter, the instruction memory and the decoder.

---
 rtl/fetch_sequencer.sv | 109 ++++++++++
 tb/tb_fetch_sequencer.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: owns the fetch address, registers memory words toward the decoder and applies redirects
// Optional feature macro RETURN_STACK_EN: builds the return-address stack; without it call acts as jump and ret is ignored
module fetch_sequencer #(
    parameter int WIDTH         = 16,
    parameter int COUNTER_WIDTH = 8,
    parameter int STACK_DEPTH   = 4,
    parameter int RESET_VECTOR  = 0,
    parameter bit START_HALTED  = 1'b0
) (
    input  logic                     clock,
    input  logic                     reset,
    output logic [COUNTER_WIDTH-1:0] count,
    input  logic [WIDTH-1:0]         mem_instr,
    output logic [WIDTH-1:0]         instruction,
    output logic [COUNTER_WIDTH-1:0] instr_pc,
    output logic                     instr_valid,
    input  logic                     instr_ready,
    input  logic                     jump_req,
    input  logic                     call_req,
    input  logic                     ret_req,
    input  logic [COUNTER_WIDTH-1:0] jump_target,
    input  logic                     halt_req,
    input  logic                     run,
    output logic                     halted,
    output logic                     stack_err
);
    typedef enum logic {RUN, HALT} state_t;
    state_t state, state_next;
    logic xfer, ret_en, do_halt, do_ret, do_call, do_jump, redirect, load, underflow;
    logic [COUNTER_WIDTH-1:0] pc_next, ret_addr;

    assign pc_next  = instr_pc + COUNTER_WIDTH'(1);
    assign xfer     = state == RUN && instr_valid && instr_ready;
    assign do_halt  = xfer && halt_req;
    assign do_ret   = xfer && !halt_req && ret_en;
    assign do_call  = xfer && !halt_req && !ret_en && call_req;
    assign do_jump  = xfer && !halt_req && !ret_en && !call_req && jump_req;
    assign redirect = do_halt || do_ret || do_call || do_jump;
    assign load     = state == RUN && (!instr_valid || instr_ready) && !redirect;
    assign halted   = state == HALT;

`ifdef RETURN_STACK_EN
    localparam int PW = $clog2(STACK_DEPTH + 1);
    localparam int AW = STACK_DEPTH > 1 ? $clog2(STACK_DEPTH) : 1;
    logic [COUNTER_WIDTH-1:0] stack [STACK_DEPTH];
    logic [PW-1:0] ptr;
    logic overflow;
    assign ret_en    = ret_req;
    assign underflow = ptr == '0;
    assign overflow  = ptr == PW'(STACK_DEPTH);
    assign ret_addr  = stack[AW'(ptr - PW'(1))];

    // Push on call and pop on ret; overflow and underflow only raise the sticky error
    always_ff @(posedge clock) begin
        if (reset) begin
            ptr       <= '0;
            stack_err <= 1'b0;
        end else if (do_ret) begin
            if (underflow) stack_err <= 1'b1;
            else ptr <= ptr - PW'(1);
        end else if (do_call) begin
            if (overflow) stack_err <= 1'b1;
            else begin
                stack[AW'(ptr)] <= pc_next;
                ptr             <= ptr + PW'(1);
            end
        end
    end
`else
    localparam int unused_depth = STACK_DEPTH;
    logic unused_ret;
    assign unused_ret = ret_req;
    assign ret_en     = 1'b0;
    assign underflow  = 1'b0;
    assign ret_addr   = '0;
    assign stack_err  = 1'b0;
`endif

    // State register
    always_ff @(posedge clock) begin
        if (reset) state <= START_HALTED ? HALT : RUN;
        else state <= state_next;
    end

    // HALT is left only by run; RUN halts on a qualified halt or a return underflow
    always_comb begin
        state_next = state;
        if (state == HALT) state_next = run ? RUN : HALT;
        else if (do_halt || (do_ret && underflow)) state_next = HALT;
    end

    // Holding register and fetch address: load, squash on redirect, or hold while stalled
    always_ff @(posedge clock) begin
        if (reset) begin
            count       <= COUNTER_WIDTH'(RESET_VECTOR);
            instruction <= '0;
            instr_pc    <= '0;
            instr_valid <= 1'b0;
        end else if (load) begin
            instruction <= mem_instr;
            instr_pc    <= count;
            instr_valid <= 1'b1;
            count       <= count + COUNTER_WIDTH'(1);
        end else if (redirect) begin
            instr_valid <= 1'b0;
            count       <= do_halt ? pc_next : do_ret ? (underflow ? count : ret_addr) : jump_target;
        end
    end
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: directed scenarios plus randomized traffic against a transfer-level reference model
`timescale 1ns/1ps
module tb_fetch_sequencer;
    localparam int W = 16, CW = 8, DEPTH = 4;
`ifdef RETURN_STACK_EN
    localparam bit STK = 1'b1;
`else
    localparam bit STK = 1'b0;
`endif
    logic clock = 1'b0;
    logic reset = 1'b1;
    logic [CW-1:0] count, instr_pc, jump_target;
    logic [W-1:0] mem_instr, instruction;
    logic instr_valid, instr_ready, jump_req, call_req, ret_req, halt_req, run, halted, stack_err;
    logic [W-1:0] mem [256];
    int n_checks = 0, n_fail = 0;

    fetch_sequencer #(.WIDTH(W), .COUNTER_WIDTH(CW), .STACK_DEPTH(DEPTH), .RESET_VECTOR(0), .START_HALTED(1'b0)) dut (
        .clock(clock), .reset(reset), .count(count), .mem_instr(mem_instr), .instruction(instruction),
        .instr_pc(instr_pc), .instr_valid(instr_valid), .instr_ready(instr_ready), .jump_req(jump_req),
        .call_req(call_req), .ret_req(ret_req), .jump_target(jump_target), .halt_req(halt_req), .run(run),
        .halted(halted), .stack_err(stack_err)
    );

    always #5 clock = ~clock;
    assign mem_instr = mem[count];

    task automatic quiet;
        instr_ready = 1'b1; jump_req = 1'b0; call_req = 1'b0; ret_req = 1'b0;
        halt_req = 1'b0; run = 1'b0; jump_target = '0;
    endtask

    task automatic ramp_mem;
        for (int i = 0; i < 256; i++) mem[i] = W'(i);
    endtask

    task automatic do_reset;
        @(negedge clock);
        reset = 1'b1;
        quiet();
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_reset;
        @(negedge clock);
        reset = 1'b1; instr_ready = 1'b1; jump_req = 1'b1; call_req = 1'b1; ret_req = 1'b1;
        halt_req = 1'b1; run = 1'b1; jump_target = 8'h55;
        repeat (2) @(negedge clock);
        n_checks++;
        if ({count, instr_pc, instruction, instr_valid, halted, stack_err} !== {8'h00, 8'h00, 16'h0000, 3'b000}) begin
            n_fail++;
            $display("FAIL reset_state: got count=%h pc=%h instr=%h v=%b h=%b e=%b exp all zero", count, instr_pc, instruction, instr_valid, halted, stack_err);
        end
        reset = 1'b0;
        quiet();
    endtask

    task automatic test_sequence_stall;
        do_reset();
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            n_checks++;
            if ({instr_valid, instr_pc, instruction, count} !== {1'b1, CW'(k), W'(k), CW'(k + 1)}) begin
                n_fail++;
                $display("FAIL seq_%0d: got v=%b pc=%h instr=%h count=%h exp pc=%h count=%h", k, instr_valid, instr_pc, instruction, count, CW'(k), CW'(k + 1));
            end
        end
        instr_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            n_checks++;
            if ({instr_valid, instr_pc, instruction, count} !== {1'b1, 8'h03, 16'h0003, 8'h04}) begin
                n_fail++;
                $display("FAIL stall_hold_%0d: got v=%b pc=%h instr=%h count=%h exp pc=03 count=04", k, instr_valid, instr_pc, instruction, count);
            end
        end
        instr_ready = 1'b1;
        for (int k = 4; k < 6; k++) begin
            @(negedge clock);
            n_checks++;
            if ({instr_valid, instr_pc, instruction} !== {1'b1, CW'(k), W'(k)}) begin
                n_fail++;
                $display("FAIL stall_resume_%0d: got v=%b pc=%h instr=%h exp pc=%h", k, instr_valid, instr_pc, instruction, CW'(k));
            end
        end
    endtask

    task automatic test_jump;
        do_reset();
        repeat (6) @(negedge clock);
        jump_req = 1'b1; jump_target = 8'h20;
        @(negedge clock);
        jump_req = 1'b0;
        n_checks++;
        if ({instr_valid, count} !== {1'b0, 8'h20}) begin
            n_fail++;
            $display("FAIL jump_bubble: got v=%b count=%h exp v=0 count=20", instr_valid, count);
        end
        @(negedge clock);
        n_checks++;
        if ({instr_valid, instr_pc, instruction} !== {1'b1, 8'h20, 16'h0020}) begin
            n_fail++;
            $display("FAIL jump_target: got v=%b pc=%h instr=%h exp pc=20", instr_valid, instr_pc, instruction);
        end
    endtask

    task automatic test_call_ret;
        do_reset();
        repeat (3) @(negedge clock);
        call_req = 1'b1; jump_target = 8'h10;
        @(negedge clock);
        call_req = 1'b0;
        n_checks++;
        if ({instr_valid, count} !== {1'b0, 8'h10}) begin
            n_fail++;
            $display("FAIL call_bubble: got v=%b count=%h exp v=0 count=10", instr_valid, count);
        end
        for (int k = 8'h10; k <= 8'h12; k++) begin
            @(negedge clock);
            n_checks++;
            if ({instr_valid, instr_pc} !== {1'b1, CW'(k)}) begin
                n_fail++;
                $display("FAIL call_body_%0d: got v=%b pc=%h exp pc=%h", k, instr_valid, instr_pc, CW'(k));
            end
        end
        ret_req = 1'b1;
        @(negedge clock);
        ret_req = 1'b0;
        n_checks++;
        if ({instr_valid, count} !== (STK ? {1'b0, 8'h03} : {1'b1, 8'h14})) begin
            n_fail++;
            $display("FAIL ret_redirect: got v=%b count=%h exp v=%b count=%h", instr_valid, count, !STK, STK ? 8'h03 : 8'h14);
        end
        if (STK) @(negedge clock);
        n_checks++;
        if ({instr_valid, instr_pc} !== {1'b1, STK ? 8'h03 : 8'h13}) begin
            n_fail++;
            $display("FAIL ret_resume: got v=%b pc=%h exp pc=%h", instr_valid, instr_pc, STK ? 8'h03 : 8'h13);
        end
        for (int i = 0; i < 5; i++) begin
            call_req = 1'b1; jump_target = CW'(8'h40 + 8 * i);
            @(negedge clock);
            call_req = 1'b0;
            @(negedge clock);
            n_checks++;
            if ({instr_valid, instr_pc, stack_err} !== {1'b1, CW'(8'h40 + 8 * i), STK && i == 4}) begin
                n_fail++;
                $display("FAIL nested_call_%0d: got v=%b pc=%h err=%b exp pc=%h err=%b", i, instr_valid, instr_pc, stack_err, CW'(8'h40 + 8 * i), STK && i == 4);
            end
        end
    endtask

    task automatic test_halt;
        do_reset();
        repeat (8) @(negedge clock);
        halt_req = 1'b1;
        @(negedge clock);
        halt_req = 1'b0;
        for (int k = 0; k < 3; k++) begin
            n_checks++;
            if ({halted, instr_valid, count} !== {1'b1, 1'b0, 8'h08}) begin
                n_fail++;
                $display("FAIL halt_hold_%0d: got h=%b v=%b count=%h exp h=1 v=0 count=08", k, halted, instr_valid, count);
            end
            if (k < 2) @(negedge clock);
        end
        run = 1'b1;
        @(negedge clock);
        run = 1'b0;
        n_checks++;
        if ({halted, instr_valid} !== 2'b00) begin
            n_fail++;
            $display("FAIL run_exit: got h=%b v=%b exp h=0 v=0", halted, instr_valid);
        end
        @(negedge clock);
        n_checks++;
        if ({instr_valid, instr_pc, instruction} !== {1'b1, 8'h08, 16'h0008}) begin
            n_fail++;
            $display("FAIL run_resume: got v=%b pc=%h instr=%h exp pc=08", instr_valid, instr_pc, instruction);
        end
        ret_req = 1'b1;
        @(negedge clock);
        ret_req = 1'b0;
        n_checks++;
        if ({stack_err, halted, instr_valid, count} !== (STK ? {3'b110, 8'h09} : {3'b001, 8'h0A})) begin
            n_fail++;
            $display("FAIL ret_underflow: got e=%b h=%b v=%b count=%h exp e=%b h=%b count=%h", stack_err, halted, instr_valid, count, STK, STK, STK ? 8'h09 : 8'h0A);
        end
    endtask

    task automatic test_priority;
        do_reset();
        repeat (2) @(negedge clock);
        halt_req = 1'b1; ret_req = 1'b1; call_req = 1'b1; jump_req = 1'b1; jump_target = 8'h77;
        @(negedge clock);
        quiet();
        n_checks++;
        if ({halted, instr_valid, count, stack_err} !== {1'b1, 1'b0, 8'h02, 1'b0}) begin
            n_fail++;
            $display("FAIL prio_halt: got h=%b v=%b count=%h e=%b exp h=1 v=0 count=02 e=0", halted, instr_valid, count, stack_err);
        end
        run = 1'b1;
        @(negedge clock);
        run = 1'b0;
        @(negedge clock);
        ret_req = 1'b1; call_req = 1'b1; jump_req = 1'b1; jump_target = 8'h30;
        @(negedge clock);
        quiet();
        n_checks++;
        if ({stack_err, halted, instr_valid, count} !== (STK ? {3'b110, 8'h03} : {3'b000, 8'h30})) begin
            n_fail++;
            $display("FAIL prio_ret: got e=%b h=%b v=%b count=%h exp count=%h", stack_err, halted, instr_valid, count, STK ? 8'h03 : 8'h30);
        end
    endtask

    task automatic test_wrap_reset;
        do_reset();
        @(negedge clock);
        jump_req = 1'b1; jump_target = 8'hFE;
        @(negedge clock);
        jump_req = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            n_checks++;
            if ({instr_valid, instr_pc} !== {1'b1, CW'(8'hFE + k)}) begin
                n_fail++;
                $display("FAIL wrap_%0d: got v=%b pc=%h exp pc=%h", k, instr_valid, instr_pc, CW'(8'hFE + k));
            end
        end
        jump_req = 1'b1; jump_target = 8'hFF;
        @(negedge clock);
        jump_req = 1'b0;
        @(negedge clock);
        call_req = 1'b1; jump_target = 8'h50;
        @(negedge clock);
        call_req = 1'b0;
        @(negedge clock);
        ret_req = 1'b1;
        @(negedge clock);
        ret_req = 1'b0;
        if (STK) @(negedge clock);
        n_checks++;
        if ({instr_valid, instr_pc} !== {1'b1, STK ? 8'h00 : 8'h51}) begin
            n_fail++;
            $display("FAIL wrap_push: got v=%b pc=%h exp pc=%h", instr_valid, instr_pc, STK ? 8'h00 : 8'h51);
        end
        call_req = 1'b1; jump_target = 8'h60;
        @(negedge clock);
        call_req = 1'b0;
        do_reset();
        n_checks++;
        if ({count, stack_err, instr_valid, halted} !== {8'h00, 3'b000}) begin
            n_fail++;
            $display("FAIL midcall_reset: got count=%h e=%b v=%b h=%b exp all zero", count, stack_err, instr_valid, halted);
        end
        @(negedge clock);
        ret_req = 1'b1;
        @(negedge clock);
        ret_req = 1'b0;
        n_checks++;
        if ({stack_err, halted} !== {STK, STK}) begin
            n_fail++;
            $display("FAIL midcall_ptr: got e=%b h=%b exp e=%b h=%b", stack_err, halted, STK, STK);
        end
    endtask

    task automatic test_random;
        logic [CW-1:0] exp_pc;
        logic [CW-1:0] stk [$];
        bit m_halted, m_err;
        int xfers;
        for (int i = 0; i < 256; i++) mem[i] = W'($urandom);
        do_reset();
        exp_pc = '0; m_halted = 1'b0; m_err = 1'b0; xfers = 0; stk.delete();
        repeat (3000) begin
            @(negedge clock);
            n_checks++;
            if ({halted, stack_err} !== {m_halted, m_err}) begin
                n_fail++;
                $display("FAIL rand_flags: got h=%b e=%b exp h=%b e=%b at %0t", halted, stack_err, m_halted, m_err, $time);
            end
            instr_ready = $urandom_range(3) != 0;
            run         = $urandom_range(4) == 0;
            halt_req    = $urandom_range(19) == 0;
            ret_req     = stk.size() > 0 && $urandom_range(4) == 0;
            call_req    = stk.size() < DEPTH && $urandom_range(5) == 0;
            jump_req    = $urandom_range(5) == 0;
            jump_target = CW'($urandom);
            if (m_halted) begin
                n_checks++;
                if (instr_valid !== 1'b0) begin
                    n_fail++;
                    $display("FAIL rand_halt_valid: got v=%b exp v=0 at %0t", instr_valid, $time);
                end
                if (run) m_halted = 1'b0;
            end else if (instr_valid && instr_ready) begin
                xfers++;
                n_checks++;
                if ({instr_pc, instruction} !== {exp_pc, mem[exp_pc]}) begin
                    n_fail++;
                    $display("FAIL rand_xfer: got pc=%h instr=%h exp pc=%h instr=%h at %0t", instr_pc, instruction, exp_pc, mem[exp_pc], $time);
                end
                if (halt_req) begin
                    m_halted = 1'b1;
                    exp_pc   = exp_pc + 1'b1;
                end else if (ret_req) exp_pc = stk.pop_back();
                else if (call_req || jump_req) begin
                    if (STK && call_req) stk.push_back(exp_pc + 1'b1);
                    exp_pc = jump_target;
                end else exp_pc = exp_pc + 1'b1;
            end
        end
        quiet();
        n_checks++;
        if (xfers < 500) begin
            n_fail++;
            $display("FAIL rand_progress: got %0d transfers exp at least 500", xfers);
        end
    endtask

    initial begin
        quiet();
        ramp_mem();
        test_reset();
        test_sequence_stall();
        test_jump();
        test_call_ret();
        test_halt();
        test_priority();
        test_wrap_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end
endmodule
